// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: RAW stall/forward select, branch squash, memory freeze.
// Optional build macro HAZARD_FORWARDING_EN enables operand forwarding selects.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_src1_v,
  input  logic             id_src2_v,
  input  logic [4:0]       exe_src1,
  input  logic [4:0]       exe_src2,
  input  logic [4:0]       exe_st_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic [4:0]       wb_dest,
  input  logic             wb_wb_en,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic [1:0]       src1_mux,
  output logic [1:0]       src2_mux,
  output logic [1:0]       st_mux,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_d;
  logic          pend_q;
  logic          frz, brn, haz, haz_raw, stall_hit;

  function automatic logic hit(
    input logic [4:0] src,
    input logic [4:0] dst,
    input logic       en
  );
    return en && (src != 5'd0) && (src == dst);
  endfunction

`ifdef HAZARD_FORWARDING_EN
  function automatic logic [1:0] fsel(
    input logic [4:0] src,
    input logic [4:0] m_dst,
    input logic       m_en,
    input logic [4:0] w_dst,
    input logic       w_en
  );
    if (hit(src, m_dst, m_en))
      return 2'd1;
    else if (hit(src, w_dst, w_en))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  logic       ld_exe;
  logic       m_fwd_en;
  logic [1:0] s1_sel, s2_sel, st_sel;

  assign ld_exe   = exe_wb_en & exe_mem_r_en;
  assign m_fwd_en = mem_wb_en & ~mem_r_en;
  assign haz_raw  =
    (id_src1_v & hit(id_src1, exe_dest, ld_exe)) |
    (id_src2_v & hit(id_src2, exe_dest, ld_exe));

  assign s1_sel =
    fsel(exe_src1, mem_dest, m_fwd_en, wb_dest, wb_wb_en);
  assign s2_sel =
    fsel(exe_src2, mem_dest, m_fwd_en, wb_dest, wb_wb_en);
  assign st_sel =
    fsel(exe_st_src, mem_dest, m_fwd_en, wb_dest, wb_wb_en);

  assign src1_mux = rst_n ? s1_sel : 2'd0;
  assign src2_mux = rst_n ? s2_sel : 2'd0;
  assign st_mux   = rst_n ? st_sel : 2'd0;
`else
  logic unused_fwd;

  // Without forwarding, a producer in EXE or MEM blocks ID until it reaches WB.
  assign haz_raw =
    (id_src1_v & hit(id_src1, exe_dest, exe_wb_en)) |
    (id_src1_v & hit(id_src1, mem_dest, mem_wb_en)) |
    (id_src2_v & hit(id_src2, exe_dest, exe_wb_en)) |
    (id_src2_v & hit(id_src2, mem_dest, mem_wb_en));

  assign src1_mux = 2'd0;
  assign src2_mux = 2'd0;
  assign st_mux   = 2'd0;

  assign unused_fwd = ^{exe_src1, exe_src2, exe_st_src,
                        exe_mem_r_en, mem_r_en, wb_dest, wb_wb_en};
`endif

  assign frz = (dmem_req & ~dmem_ready) | (state_q == ERROR);
  assign brn = (branch_taken | pend_q) & ~frz;
  assign haz = haz_raw & ~frz & ~(branch_taken | pend_q);

  // Pipeline control: freeze over branch over hazard stall.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    stall_hit   = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        frz: begin
          pipe_freeze = 1'b1;
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
        end
        brn: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        haz: begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          stall_hit   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory-wait FSM next state and timeout detection.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = mem_timeout;
    unique case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d = MEM_WAIT;
          wait_d  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
          state_d   = ERROR;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ERROR: state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  // State, pending branch and saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_q      <= '0;
      mem_timeout <= 1'b0;
      pend_q      <= 1'b0;
      stall_cnt   <= '0;
      freeze_cnt  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_timeout <= timeout_d;
      if (frz && branch_taken)
        pend_q <= 1'b1;
      else if (!frz)
        pend_q <= 1'b0;
      if (stall_hit && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pipe_freeze && (freeze_cnt != '1))
        freeze_cnt <= freeze_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized and directed bench for hazard_controller.
// Reference model works from stage-level rules, not the RTL encoding.
module tb_hazard_controller;

  localparam int T     = 16;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD   = 1'b1;
`else
  localparam bit FWD   = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [4:0]    id_src1, id_src2;
  logic          id_src1_v, id_src2_v;
  logic [4:0]    exe_src1, exe_src2, exe_st_src, exe_dest;
  logic          exe_wb_en, exe_mem_r_en;
  logic [4:0]    mem_dest;
  logic          mem_wb_en, mem_r_en;
  logic [4:0]    wb_dest;
  logic          wb_wb_en;
  logic          branch_taken, dmem_req, dmem_ready;
  logic          pc_hold, ifid_hold, idex_bubble, ifid_flush;
  logic          pipe_freeze, mem_timeout;
  logic [1:0]    src1_mux, src2_mux, st_mux;
  logic [CW-1:0] stall_cnt, freeze_cnt;

  hazard_controller #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_v(id_src1_v), .id_src2_v(id_src2_v),
    .exe_src1(exe_src1), .exe_src2(exe_src2),
    .exe_st_src(exe_st_src), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .pipe_freeze(pipe_freeze),
    .src1_mux(src1_mux), .src2_mux(src2_mux), .st_mux(st_mux),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model state
  bit m_known = 0;
  bit m_err = 0;
  bit m_inwait = 0;
  int m_low = 0;
  bit m_to = 0;
  int m_sc = 0;
  int m_fc = 0;
  bit m_pend = 0;

  // expected combinational outputs
  bit e_frz, e_br, e_stall;
  int e_m1, e_m2, e_ms;

  function automatic bit blocked(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (FWD)
      return exe_wb_en && exe_mem_r_en && exe_dest == r;
    return (exe_wb_en && exe_dest == r) ||
           (mem_wb_en && mem_dest == r);
  endfunction

  function automatic int fwd_of(input logic [4:0] r);
    if (!FWD || r == 5'd0) return 0;
    if (mem_wb_en && !mem_r_en && mem_dest == r) return 1;
    if (wb_wb_en && wb_dest == r) return 2;
    return 0;
  endfunction

  task automatic model_comb();
    bit hz;
    hz = (id_src1_v && blocked(id_src1)) ||
         (id_src2_v && blocked(id_src2));
    e_frz   = rst_n && ((dmem_req && !dmem_ready) || m_err);
    e_br    = rst_n && !e_frz && (branch_taken || m_pend);
    e_stall = rst_n && !e_frz && !(branch_taken || m_pend) && hz;
    e_m1 = rst_n ? fwd_of(exe_src1) : 0;
    e_m2 = rst_n ? fwd_of(exe_src2) : 0;
    e_ms = rst_n ? fwd_of(exe_st_src) : 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_known = 1; m_err = 0; m_inwait = 0; m_low = 0;
      m_to = 0; m_sc = 0; m_fc = 0; m_pend = 0;
      return;
    end
    if (e_stall && m_sc < CMAX) m_sc++;
    if (e_frz && m_fc < CMAX) m_fc++;
    if (e_frz && branch_taken) m_pend = 1;
    else if (!e_frz) m_pend = 0;
    if (m_err) return;
    if (!m_inwait) begin
      if (dmem_req && !dmem_ready) begin
        m_inwait = 1;
        m_low = 1;
      end
    end else if (dmem_ready) begin
      m_inwait = 0;
    end else begin
      m_low++;
      if (m_low == T) begin
        m_err = 1;
        m_to = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_comb();
    check("pc_hold", pc_hold, e_frz || e_stall);
    check("ifid_hold", ifid_hold, e_frz || e_stall);
    check("idex_bubble", idex_bubble, e_br || e_stall);
    check("ifid_flush", ifid_flush, e_br);
    check("pipe_freeze", pipe_freeze, e_frz);
    check("src1_mux", src1_mux, e_m1);
    check("src2_mux", src2_mux, e_m2);
    check("st_mux", st_mux, e_ms);
    if (m_known) begin
      check("mem_timeout", mem_timeout, m_to);
      check("stall_cnt", stall_cnt, m_sc);
      check("freeze_cnt", freeze_cnt, m_fc);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_ins();
    id_src1 = 0; id_src2 = 0; id_src1_v = 0; id_src2_v = 0;
    exe_src1 = 0; exe_src2 = 0; exe_st_src = 0; exe_dest = 0;
    exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; mem_r_en = 0;
    wb_dest = 0; wb_wb_en = 0;
    branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  int n;

  initial begin
    clear_ins();
    rst_n = 0;
    branch_taken = 1;
    #1;
    tick();
    tick();
    check("rst_flush", ifid_flush, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_freeze_cnt", freeze_cnt, 0);
    check("rst_timeout", mem_timeout, 0);

    // forwarding selects
    rst_n = 1;
    clear_ins();
    mem_dest = 5; mem_wb_en = 1; exe_src1 = 5;
    wb_dest = 5; wb_wb_en = 1;
    #2;
    check("fwd_mem", src1_mux, FWD ? 1 : 0);
    tick();
    mem_wb_en = 0;
    #2;
    check("fwd_wb", src1_mux, FWD ? 2 : 0);
    tick();
    exe_src1 = 0;
    #2;
    check("fwd_r0", src1_mux, 0);
    tick();

    // load-use stall, moving the load down the pipe
    clear_ins();
    n = 0;
    id_src2 = 3; id_src2_v = 1;
    exe_dest = 3; exe_wb_en = 1; exe_mem_r_en = 1;
    #2; if (pc_hold) n++;
    tick();
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 3; mem_wb_en = 1; mem_r_en = 1;
    #2; if (pc_hold) n++;
    tick();
    mem_dest = 0; mem_wb_en = 0; mem_r_en = 0;
    wb_dest = 3; wb_wb_en = 1;
    #2; if (pc_hold) n++;
    tick();
    check("stall_len", n, FWD ? 1 : 2);
    check("stall_cnt_lu", stall_cnt, FWD ? 1 : 2);

    // branch beats the stall
    clear_ins();
    id_src2 = 3; id_src2_v = 1;
    exe_dest = 3; exe_wb_en = 1; exe_mem_r_en = 1;
    branch_taken = 1;
    #2;
    check("br_flush", ifid_flush, 1);
    check("br_bubble", idex_bubble, 1);
    check("br_pc_hold", pc_hold, 0);
    check("br_ifid_hold", ifid_hold, 0);
    tick();

    // memory wait of 5 cycles
    clear_ins();
    n = 0;
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #2; if (pipe_freeze) n++;
      tick();
    end
    dmem_ready = 1;
    #2;
    check("wait_release", pipe_freeze, 0);
    tick();
    check("wait_len", n, 5);
    check("wait_freeze_cnt", freeze_cnt, 5);
    check("wait_timeout", mem_timeout, 0);

    // timeout
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < T; i++) tick();
    clear_ins();
    dmem_ready = 1;
    #2;
    check("to_flag", mem_timeout, 1);
    check("to_freeze", pipe_freeze, 1);
    tick();
    tick();
    check("to_sat", freeze_cnt, CMAX);
    rst_n = 0;
    #2;
    check("to_rst_freeze", pipe_freeze, 0);
    tick();
    check("to_rst_flag", mem_timeout, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      id_src1 = 5'($urandom_range(0, 3));
      id_src2 = 5'($urandom_range(0, 3));
      id_src1_v = 1'($urandom);
      id_src2_v = 1'($urandom);
      exe_src1 = 5'($urandom_range(0, 3));
      exe_src2 = 5'($urandom_range(0, 3));
      exe_st_src = 5'($urandom_range(0, 3));
      exe_dest = 5'($urandom_range(0, 3));
      exe_wb_en = 1'($urandom);
      exe_mem_r_en = 1'($urandom);
      mem_dest = 5'($urandom_range(0, 3));
      mem_wb_en = 1'($urandom);
      mem_r_en = 1'($urandom);
      wb_dest = 5'($urandom_range(0, 3));
      wb_wb_en = 1'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      dmem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
